// File: rtl/fire_event_controller.sv
// Fire-detection sequencer: periodic sampling, 2-of-3 vote, confirm/clear FSM, latched alarm.
// Define FIRE_FAULT_MON_EN to build the per-sensor disagreement fault monitor.
module fire_event_controller #(
    parameter int unsigned SAMPLE_DIV  = 100,
    parameter int unsigned CONFIRM_CNT = 3,
    parameter int unsigned CLEAR_CNT   = 4,
    parameter int unsigned FAULT_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       temperature,
    input  logic       smoke,
    input  logic       humidity,
    input  logic       alarm_ack,
    output logic       alarm,
    output logic       event_valid,
    output logic [2:0] flag,
    output logic [1:0] state,
    output logic [2:0] sensor_fault
);

    localparam int unsigned TW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned CFW = $clog2(CONFIRM_CNT + 1);
    localparam int unsigned CLW = $clog2(CLEAR_CNT + 1);
    localparam logic [TW-1:0]  TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [CFW-1:0] CONF_LAST = CFW'(CONFIRM_CNT - 1);
    localparam logic [CLW-1:0] CLR_LAST  = CLW'(CLEAR_CNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUSPECT = 2'd1,
        ALARM   = 2'd2,
        HOLD    = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [CFW-1:0] conf_q, conf_d;
    logic [CLW-1:0] clr_q, clr_d;
    logic           alarm_q, alarm_d;
    logic           event_q, event_d;
    logic [2:0]     flag_q, flag_d;
    logic           tick_c;
    logic [2:0]     sense_c;
    logic           vote_c;

    assign sense_c = {temperature, smoke, humidity};
    assign vote_c  = (sense_c[2] & sense_c[1]) | (sense_c[2] & sense_c[0]) | (sense_c[1] & sense_c[0]);

    // Sample tick divider; held at zero while disabled
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        tick_c     = 1'b0;
        if (!enable) begin
            tick_cnt_d = '0;
        end else if (tick_cnt_q >= TICK_LAST) begin
            tick_c     = 1'b1;
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; ack in ALARM takes priority over a coincident tick
    always_comb begin
        state_d = state_q;
        conf_d  = conf_q;
        clr_d   = clr_q;
        if (!enable) begin
            state_d = IDLE;
            conf_d  = '0;
            clr_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick_c && vote_c) begin
                        if (CONFIRM_CNT == 1) begin
                            state_d = ALARM;
                            conf_d  = '0;
                        end else begin
                            state_d = SUSPECT;
                            conf_d  = CFW'(1);
                        end
                    end
                end
                SUSPECT: begin
                    if (tick_c) begin
                        if (!vote_c) begin
                            state_d = IDLE;
                            conf_d  = '0;
                        end else if (conf_q >= CONF_LAST) begin
                            state_d = ALARM;
                            conf_d  = '0;
                        end else begin
                            conf_d = conf_q + CFW'(1);
                        end
                    end
                end
                ALARM: begin
                    if (alarm_ack) begin
                        state_d = HOLD;
                        clr_d   = '0;
                    end
                end
                HOLD: begin
                    if (tick_c) begin
                        if (vote_c) begin
                            clr_d = '0;
                        end else if (clr_q >= CLR_LAST) begin
                            state_d = IDLE;
                            clr_d   = '0;
                        end else begin
                            clr_d = clr_q + CLW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Registered outputs computed from the upcoming state so they align with ALARM entry
    always_comb begin
        alarm_d = (state_d == ALARM);
        event_d = (state_d == ALARM) && (state_q != ALARM);
        flag_d  = tick_c ? sense_c : flag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            conf_q     <= '0;
            clr_q      <= '0;
            alarm_q    <= 1'b0;
            event_q    <= 1'b0;
            flag_q     <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            conf_q     <= conf_d;
            clr_q      <= clr_d;
            alarm_q    <= alarm_d;
            event_q    <= event_d;
            flag_q     <= flag_d;
        end
    end

    assign alarm       = alarm_q;
    assign event_valid = event_q;
    assign flag        = flag_q;
    assign state       = state_q;

`ifdef FIRE_FAULT_MON_EN
    localparam int unsigned DW = $clog2(FAULT_LIMIT + 1);
    localparam logic [DW-1:0] DIS_MAX = DW'(FAULT_LIMIT);

    logic [DW-1:0] dis_q [3];
    logic [DW-1:0] dis_d [3];
    logic [2:0]    fault_q, fault_d;

    // Disagreement run length per sensor; fault bit is sticky until reset
    always_comb begin
        fault_d = fault_q;
        for (int i = 0; i < 3; i++) begin
            dis_d[i] = dis_q[i];
            if (tick_c) begin
                if (sense_c[i] != vote_c) begin
                    if (dis_q[i] < DIS_MAX) begin
                        dis_d[i] = dis_q[i] + DW'(1);
                    end
                end else begin
                    dis_d[i] = '0;
                end
                if (dis_d[i] == DIS_MAX) begin
                    fault_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                dis_q[i] <= '0;
            end
            fault_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                dis_q[i] <= dis_d[i];
            end
            fault_q <= fault_d;
        end
    end

    assign sensor_fault = fault_q;
`else
    logic unused_fault_limit;
    assign unused_fault_limit = |FAULT_LIMIT;
    assign sensor_fault       = 3'b000;
`endif

endmodule

// File: tb/tb_fire_event_controller.sv
// Scoreboard bench for fire_event_controller: stimulus pushes expected snapshots, monitor compares.
module tb_fire_event_controller;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SUSPECT = 2'd1;
    localparam logic [1:0] S_ALARM   = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n, enable, temperature, smoke, humidity, alarm_ack;
    logic       alarm, event_valid;
    logic [2:0] flag, sensor_fault;
    logic [1:0] state;

    fire_event_controller #(
        .SAMPLE_DIV (4),
        .CONFIRM_CNT(3),
        .CLEAR_CNT  (2),
        .FAULT_LIMIT(3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .temperature (temperature),
        .smoke       (smoke),
        .humidity    (humidity),
        .alarm_ack   (alarm_ack),
        .alarm       (alarm),
        .event_valid (event_valid),
        .flag        (flag),
        .state       (state),
        .sensor_fault(sensor_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic       al;
        logic       ev;
        logic [2:0] fl;
        logic [2:0] sf;
        string      nm;
    } snap_t;

    snap_t      snap_q[$];
    logic [2:0] ev_q[$];
    int         checks   = 0;
    int         failures = 0;

    logic [1:0] e_st;
    logic       e_al, e_ev;
    logic [2:0] e_fl, e_sf;
    int         ph;
    string      cur_nm;
`ifdef FIRE_FAULT_MON_EN
    int         dis[3];
`endif

    snap_t      ms;
    logic [2:0] mf;

    // Monitor: one expected snapshot per pushed cycle, plus every event_valid pulse
    always @(negedge clk) begin
        if (snap_q.size() > 0) begin
            ms = snap_q.pop_front();
            checks++;
            if ({state, alarm, event_valid, flag, sensor_fault} !== {ms.st, ms.al, ms.ev, ms.fl, ms.sf}) begin
                failures++;
                $display("FAIL %s: got st=%0d al=%b ev=%b fl=%b sf=%b, want st=%0d al=%b ev=%b fl=%b sf=%b",
                         ms.nm, state, alarm, event_valid, flag, sensor_fault,
                         ms.st, ms.al, ms.ev, ms.fl, ms.sf);
            end
        end
        if (event_valid === 1'b1) begin
            checks++;
            if (ev_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: event_valid=1 flag=%b, want no event", flag);
            end else begin
                mf = ev_q.pop_front();
                if (flag !== mf) begin
                    failures++;
                    $display("FAIL event_flag: got %b, want %b", flag, mf);
                end
            end
        end
    end

    function automatic void push_snap(input string nm);
        snap_t s;
        s.st = e_st; s.al = e_al; s.ev = e_ev; s.fl = e_fl; s.sf = e_sf; s.nm = nm;
        snap_q.push_back(s);
    endfunction

    function automatic void model_tick(input logic [2:0] in);
`ifdef FIRE_FAULT_MON_EN
        logic v;
        v = (in[2] & in[1]) | (in[2] & in[0]) | (in[1] & in[0]);
        for (int i = 0; i < 3; i++) begin
            if (in[i] != v) begin
                if (dis[i] < 3) dis[i]++;
            end else begin
                dis[i] = 0;
            end
            if (dis[i] == 3) e_sf[i] = 1'b1;
        end
`endif
        e_fl = in;
    endfunction

    task automatic idle_step();
        @(posedge clk);
        push_snap({cur_nm, "_pre"});
        e_ev = 1'b0;
        ph++;
        @(negedge clk);
    endtask

    task automatic tick(input logic [2:0] in, input logic [1:0] st, input logic al,
                        input logic ev, input logic ack, input string nm);
        {temperature, smoke, humidity} = in;
        cur_nm = nm;
        while (ph < 3) idle_step();
        alarm_ack = ack;
        @(posedge clk);
        e_st = st; e_al = al; e_ev = ev;
        model_tick(in);
        if (ev) ev_q.push_back(in);
        push_snap(nm);
        e_ev = 1'b0;
        ph = 0;
        @(negedge clk);
        alarm_ack = 1'b0;
    endtask

    task automatic ack_pulse(input logic [1:0] st, input logic al, input string nm);
        alarm_ack = 1'b1;
        @(posedge clk);
        e_st = st; e_al = al;
        push_snap(nm);
        ph++;
        @(negedge clk);
        alarm_ack = 1'b0;
    endtask

    task automatic disable_step(input string nm);
        enable = 1'b0;
        @(posedge clk);
        e_st = S_IDLE; e_al = 1'b0; e_ev = 1'b0;
        push_snap(nm);
        ph = 0;
        @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic async_reset(input string nm);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        e_st = S_IDLE; e_al = 1'b0; e_ev = 1'b0; e_fl = 3'b000; e_sf = 3'b000;
`ifdef FIRE_FAULT_MON_EN
        for (int i = 0; i < 3; i++) dis[i] = 0;
`endif
        ph = 0;
        push_snap(nm);
        @(negedge clk);
        cur_nm = {nm, "_held"};
        idle_step();
        ph = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want normal end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; alarm_ack = 1'b0;
        {temperature, smoke, humidity} = 3'b000;
        e_st = S_IDLE; e_al = 1'b0; e_ev = 1'b0; e_fl = 3'b000; e_sf = 3'b000;
        ph = 0;
        cur_nm = "reset";
`ifdef FIRE_FAULT_MON_EN
        for (int i = 0; i < 3; i++) dis[i] = 0;
`endif
        @(negedge clk);
        idle_step();
        rst_n = 1'b1;
        enable = 1'b1;
        ph = 0;

        // Confirm over three 011 ticks
        tick(3'b011, S_SUSPECT, 1'b0, 1'b0, 1'b0, "s1_t1");
        tick(3'b011, S_SUSPECT, 1'b0, 1'b0, 1'b0, "s1_t2");
        tick(3'b011, S_ALARM,   1'b1, 1'b1, 1'b0, "s1_t3");
        cur_nm = "s1_after";
        idle_step();

        // Ack, then clear with a 111 tick restarting the clear count
        ack_pulse(S_HOLD, 1'b0, "s3_ack");
        tick(3'b000, S_HOLD, 1'b0, 1'b0, 1'b0, "s3_z1");
        tick(3'b111, S_HOLD, 1'b0, 1'b0, 1'b0, "s3_one");
        tick(3'b000, S_HOLD, 1'b0, 1'b0, 1'b0, "s3_z2");
        tick(3'b000, S_IDLE, 1'b0, 1'b0, 1'b0, "s3_z3");
        ack_pulse(S_IDLE, 1'b0, "ack_in_idle");

        // Ack coincident with a 111 tick in ALARM
        tick(3'b111, S_SUSPECT, 1'b0, 1'b0, 1'b0, "s4_t1");
        tick(3'b111, S_SUSPECT, 1'b0, 1'b0, 1'b0, "s4_t2");
        tick(3'b111, S_ALARM,   1'b1, 1'b1, 1'b0, "s4_t3");
        tick(3'b111, S_HOLD,    1'b0, 1'b0, 1'b1, "s4_ack_tick");
        tick(3'b000, S_HOLD,    1'b0, 1'b0, 1'b0, "s4_z1");
        tick(3'b000, S_IDLE,    1'b0, 1'b0, 1'b0, "s4_z2");

        // Suspect aborted by a non-majority tick
        tick(3'b110, S_SUSPECT, 1'b0, 1'b0, 1'b0, "s2_t1");
        tick(3'b110, S_SUSPECT, 1'b0, 1'b0, 1'b0, "s2_t2");
        tick(3'b100, S_IDLE,    1'b0, 1'b0, 1'b0, "s2_t3");

        // enable=0 in SUSPECT clears state and confirm count; flag holds
        tick(3'b011, S_SUSPECT, 1'b0, 1'b0, 1'b0, "s5_sus");
        disable_step("s5_disable");
        tick(3'b011, S_SUSPECT, 1'b0, 1'b0, 1'b0, "s5_r1");
        tick(3'b011, S_SUSPECT, 1'b0, 1'b0, 1'b0, "s5_r2");
        tick(3'b011, S_ALARM,   1'b1, 1'b1, 1'b0, "s5_r3");
        async_reset("s5_rst");

        // Lone smoke disagreement builds a sticky fault when the monitor is built
        tick(3'b010, S_IDLE, 1'b0, 1'b0, 1'b0, "s6_t1");
        tick(3'b010, S_IDLE, 1'b0, 1'b0, 1'b0, "s6_t2");
        tick(3'b010, S_IDLE, 1'b0, 1'b0, 1'b0, "s6_t3");
        tick(3'b000, S_IDLE, 1'b0, 1'b0, 1'b0, "s6_sticky");

        repeat (3) @(negedge clk);
        checks++;
        if (snap_q.size() != 0 || ev_q.size() != 0) begin
            failures++;
            $display("FAIL drain: snapshots=%0d events=%0d left, want 0 and 0", snap_q.size(), ev_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
